// File: rtl/multimode_countdown_if.sv
// multimode_countdown_if
//   Bundles the command inputs and status outputs of multimode_countdown.
//   master modport: the controlling side (drives commands, observes status).
//   slave modport : the counter itself.
//   Signals:
//     i_tick   decrement strobe
//     i_start  load-and-run / resume command
//     i_pause  freeze command
//     i_clear  abort to idle
//     i_mode   0 = one-shot, 1 = auto-reload (sampled on a start-load)
//     i_limit  start value (sampled on a start-load)
//     o_value  current count
//     o_expire one-cycle terminal-count pulse
//     o_busy   counting or paused
//     o_done   one-shot finished
interface multimode_countdown_if #(
  parameter int WIDTH = 7
);
  logic             i_tick;
  logic             i_start;
  logic             i_pause;
  logic             i_clear;
  logic             i_mode;
  logic [WIDTH-1:0] i_limit;
  logic [WIDTH-1:0] o_value;
  logic             o_expire;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_tick, i_start, i_pause, i_clear, i_mode, i_limit,
    input  o_value, o_expire, o_busy, o_done
  );

  modport slave (
    input  i_tick, i_start, i_pause, i_clear, i_mode, i_limit,
    output o_value, o_expire, o_busy, o_done
  );
endinterface

// File: rtl/multimode_countdown.sv
// multimode_countdown
//   Down-counter with one-shot and auto-reload modes, pause/resume and
//   synchronous clear. Command priority each cycle: clear > start > pause > tick.
//   Ports:
//     i_clk      clock, all state changes on the rising edge
//     i_reset_n  asynchronous active-low reset
//     bus        multimode_countdown_if.slave (commands in, status out)
//   All outputs come straight from flops or from the registered state.
module multimode_countdown #(
  parameter int WIDTH = 7
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  multimode_countdown_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             expire_q, expire_d;
  logic             limit_valid;

  assign limit_valid = (bus.i_limit != '0);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      expire_q <= expire_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    expire_d = 1'b0;

    if (bus.i_clear) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (bus.i_start) begin
      if (state_q == ST_PAUSED) begin
        // Resume keeps the frozen count and the originally sampled settings.
        state_d = ST_RUN;
      end else if (limit_valid) begin
        // A restart also wins over a coincident terminal tick, so no expire.
        state_d  = ST_RUN;
        count_d  = bus.i_limit;
        reload_d = bus.i_limit;
        mode_d   = bus.i_mode;
      end
      // A zero limit outside PAUSED consumes the cycle with no effect.
    end else if (bus.i_pause) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSED;
      end
    end else if (bus.i_tick && (state_q == ST_RUN)) begin
      if (count_q > ONE) begin
        count_d = count_q - ONE;
      end else begin
        // Terminal count: the count never goes below 1 while running, so
        // this branch replaces the decrement that would otherwise wrap.
        expire_d = 1'b1;
        if (mode_q) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = ST_DONE;
        end
      end
    end
  end

  assign bus.o_value  = count_q;
  assign bus.o_expire = expire_q;
  assign bus.o_busy   = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign bus.o_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_multimode_countdown.sv
// tb_multimode_countdown
//   Directed scenarios followed by a randomized command stream, each cycle
//   checked against a behavioural model of the counter; a second 16-bit
//   instance checks the full-range one-shot expiry timing.
module tb_multimode_countdown;

  localparam int W   = 7;
  localparam int W16 = 16;

  localparam int P_IDLE   = 0;
  localparam int P_RUN    = 1;
  localparam int P_PAUSED = 2;
  localparam int P_DONE   = 3;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  multimode_countdown_if #(.WIDTH(W))   ifc   ();
  multimode_countdown_if #(.WIDTH(W16)) ifc16 ();

  multimode_countdown #(.WIDTH(W)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (ifc.slave)
  );

  multimode_countdown #(.WIDTH(W16)) dut16 (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (ifc16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model
  int m_phase;
  int m_cnt;
  int m_rel;
  bit m_auto;
  bit m_exp;

  function automatic void model_reset();
    m_phase = P_IDLE;
    m_cnt   = 0;
    m_rel   = 0;
    m_auto  = 1'b0;
    m_exp   = 1'b0;
  endfunction

  function automatic void model_step(input bit tick, input bit start, input bit pause,
                                     input bit clear, input bit mode, input int limit);
    m_exp = 1'b0;
    if (clear) begin
      m_phase = P_IDLE;
      m_cnt   = 0;
    end else if (start) begin
      if (m_phase == P_PAUSED) begin
        m_phase = P_RUN;
      end else if (limit != 0) begin
        m_phase = P_RUN;
        m_cnt   = limit;
        m_rel   = limit;
        m_auto  = mode;
      end
    end else if (pause) begin
      if (m_phase == P_RUN) m_phase = P_PAUSED;
    end else if (tick && m_phase == P_RUN) begin
      if (m_cnt > 1) begin
        m_cnt = m_cnt - 1;
      end else begin
        m_exp = 1'b1;
        if (m_auto) begin
          m_cnt = m_rel;
        end else begin
          m_cnt   = 0;
          m_phase = P_DONE;
        end
      end
    end
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [W-1:0] c;
    c = W'(m_cnt);
    return 32'({c, m_exp, (m_phase == P_RUN) || (m_phase == P_PAUSED), m_phase == P_DONE});
  endfunction

  function automatic logic [31:0] dut_vec();
    return 32'({ifc.o_value, ifc.o_expire, ifc.o_busy, ifc.o_done});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (value,expire,busy,done)", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input bit tick, input bit start, input bit pause,
                      input bit clear, input bit mode, input int limit);
    ifc.i_tick  = tick;
    ifc.i_start = start;
    ifc.i_pause = pause;
    ifc.i_clear = clear;
    ifc.i_mode  = mode;
    ifc.i_limit = W'(limit);
    @(posedge clk);
    #1;
    model_step(tick, start, pause, clear, mode, limit);
    step_no++;
    check(tag, dut_vec(), exp_vec());
    $display("step %0d %s: tick=%b start=%b pause=%b clear=%b mode=%b limit=%0d -> value=%0d expire=%b busy=%b done=%b",
             step_no, tag, tick, start, pause, clear, mode, limit,
             ifc.o_value, ifc.o_expire, ifc.o_busy, ifc.o_done);
  endtask

  initial begin : stim
    bit          t, s, p, c, md;
    int          lim;
    int          early_exp;

    rst_n = 1'b0;
    ifc.i_tick = 1'b0; ifc.i_start = 1'b0; ifc.i_pause = 1'b0;
    ifc.i_clear = 1'b0; ifc.i_mode = 1'b0; ifc.i_limit = '0;
    ifc16.i_tick = 1'b0; ifc16.i_start = 1'b0; ifc16.i_pause = 1'b0;
    ifc16.i_clear = 1'b0; ifc16.i_mode = 1'b0; ifc16.i_limit = '0;
    model_reset();
    #1;
    check("reset", dut_vec(), exp_vec());
    check("reset_lit", dut_vec(), 32'd0);
    check("reset16", 32'({ifc16.o_value, ifc16.o_expire, ifc16.o_busy, ifc16.o_done}), 32'd0);

    // Release reset before the first edge with a start already present.
    ifc.i_start = 1'b1; ifc.i_limit = W'(5);
    #2;
    rst_n = 1'b1;

    // One-shot 5 -> 0
    step("os_load", 0, 1, 0, 0, 0, 5);
    check("os_load_lit", dut_vec(), 32'({7'd5, 1'b0, 1'b1, 1'b0}));
    for (int i = 0; i < 5; i++) step("os_tick", 1, 0, 0, 0, 0, 0);
    check("os_expire_lit", dut_vec(), 32'({7'd0, 1'b1, 1'b0, 1'b1}));
    step("os_hold", 1, 0, 0, 0, 0, 0);
    step("os_hold", 1, 0, 0, 0, 0, 0);
    check("os_hold_lit", dut_vec(), 32'({7'd0, 1'b0, 1'b0, 1'b1}));

    // Auto-reload period 3
    step("ar_load", 0, 1, 0, 0, 1, 3);
    for (int i = 0; i < 9; i++) step("ar_tick", 1, 0, 0, 0, 0, 0);
    check("ar_end_lit", dut_vec(), 32'({7'd3, 1'b1, 1'b1, 1'b0}));

    // Pause / resume keeps the count
    step("pr_clear", 0, 0, 0, 1, 0, 0);
    step("pr_load", 0, 1, 0, 0, 0, 10);
    for (int i = 0; i < 4; i++) step("pr_tick", 1, 0, 0, 0, 0, 0);
    step("pr_pause", 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("pr_frozen", 1, 0, 0, 0, 0, 0);
    check("pr_frozen_lit", dut_vec(), 32'({7'd6, 1'b0, 1'b1, 1'b0}));
    step("pr_resume", 0, 1, 0, 0, 1, 2);
    step("pr_tick", 1, 0, 0, 0, 0, 0);
    check("pr_resume_lit", dut_vec(), 32'({7'd5, 1'b0, 1'b1, 1'b0}));

    // Clear beats start; zero-limit start ignored
    step("cl_load", 0, 1, 0, 0, 0, 6);
    step("cl_tick", 1, 0, 0, 0, 0, 0);
    step("cl_tick", 1, 0, 0, 0, 0, 0);
    step("cl_clear_start", 1, 1, 0, 1, 0, 9);
    check("cl_idle_lit", dut_vec(), 32'd0);
    step("cl_zero_start", 1, 1, 0, 0, 1, 0);

    // Restart at terminal count, then asynchronous reset mid-count
    step("rs_load", 0, 1, 0, 0, 0, 3);
    step("rs_tick", 1, 0, 0, 0, 0, 0);
    step("rs_tick", 1, 0, 0, 0, 0, 0);
    step("rs_restart", 1, 1, 0, 0, 0, 8);
    check("rs_restart_lit", dut_vec(), 32'({7'd8, 1'b0, 1'b1, 1'b0}));
    step("rs_tick", 1, 0, 0, 0, 0, 0);
    ifc.i_tick = 1'b0; ifc.i_start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", dut_vec(), exp_vec());
    @(posedge clk);
    #1;
    check("reset_hold", dut_vec(), exp_vec());
    #2;
    rst_n = 1'b1;

    // Randomized command stream
    for (int i = 0; i < 400; i++) begin
      c   = ($urandom_range(0, 99) < 3);
      s   = ($urandom_range(0, 99) < 15);
      p   = ($urandom_range(0, 99) < 10);
      t   = ($urandom_range(0, 99) < 75);
      md  = 1'($urandom_range(0, 1));
      lim = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 4));
      step("rand", t, s, p, c, md, lim);
    end

    // 16-bit full-range one-shot
    ifc16.i_start = 1'b1; ifc16.i_mode = 1'b0; ifc16.i_limit = 16'hFFFF; ifc16.i_tick = 1'b1;
    @(posedge clk);
    #1;
    ifc16.i_start = 1'b0;
    check("w16_load", 32'({ifc16.o_value, ifc16.o_expire, ifc16.o_busy, ifc16.o_done}),
          32'({16'hFFFF, 1'b0, 1'b1, 1'b0}));
    early_exp = 0;
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
      #1;
      if (ifc16.o_expire !== 1'b0 || ifc16.o_done !== 1'b0) early_exp++;
    end
    check("w16_no_early_expire", 32'(early_exp), 32'd0);
    check("w16_at_one", 32'({ifc16.o_value, ifc16.o_expire, ifc16.o_busy, ifc16.o_done}),
          32'({16'd1, 1'b0, 1'b1, 1'b0}));
    @(posedge clk);
    #1;
    check("w16_expire", 32'({ifc16.o_value, ifc16.o_expire, ifc16.o_busy, ifc16.o_done}),
          32'({16'd0, 1'b1, 1'b0, 1'b1}));
    @(posedge clk);
    #1;
    check("w16_hold", 32'({ifc16.o_value, ifc16.o_expire, ifc16.o_busy, ifc16.o_done}),
          32'({16'd0, 1'b0, 1'b0, 1'b1}));
    $display("w16 one-shot 0xFFFF: value=%0d expire=%b done=%b", ifc16.o_value, ifc16.o_expire, ifc16.o_done);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multimode_countdown.md
MULTIMODE_COUNTDOWN -- requirements
Module: multimode_countdown

Interface
REQ-001 Parameter WIDTH, default 7, counter and limit width in bits (legal range 2..32).
REQ-002 i_clk  input  1  single clock; all state changes on posedge.
REQ-003 i_reset_n  input  1  asynchronous active-low reset.
REQ-004 i_tick  input  1  decrement strobe; one decrement per cycle high while running.
REQ-005 i_start  input  1  load-and-run or resume command, single-cycle.
REQ-006 i_pause  input  1  freeze command, single-cycle.
REQ-007 i_clear  input  1  synchronous abort to idle, single-cycle.
REQ-008 i_mode  input  1  0 = one-shot, 1 = auto-reload; sampled on each start-load.
REQ-009 i_limit  input  WIDTH  count-down start value; sampled on each start-load.
REQ-010 o_value  output  WIDTH  current count, registered.
REQ-011 o_expire  output  1  one-cycle pulse on reaching terminal count.
REQ-012 o_busy  output  1  high in RUN or PAUSED.
REQ-013 o_done  output  1  high in DONE.

Function
REQ-014 FSM states IDLE, RUN, PAUSED, DONE; all outputs registered or decoded from registered state only.
REQ-015 Priority every cycle: i_clear > i_start > i_pause > i_tick.
REQ-016 i_clear, any state: next state IDLE, count 0, o_expire 0.
REQ-017 Start-load: i_start in IDLE, DONE or RUN with i_limit != 0; count <= i_limit, reload register <= i_limit, mode register <= i_mode, next state RUN.
REQ-018 i_start with i_limit == 0 in IDLE/DONE/RUN: ignored, state and count unchanged.
REQ-019 i_start in PAUSED: resume, next state RUN, count unchanged, i_limit/i_mode not sampled.
REQ-020 i_pause in RUN: next state PAUSED, no decrement that cycle even if i_tick high; i_pause in other states ignored.
REQ-021 RUN, i_tick high, count > 1: count <= count - 1.
REQ-022 RUN, i_tick high, count == 1, mode 0: count <= 0, o_expire <= 1 for one cycle, next state DONE.
REQ-023 RUN, i_tick high, count == 1, mode 1: count <= reload register, o_expire <= 1 for one cycle, stay RUN; 0 never appears on o_value in auto-reload.
REQ-024 Auto-reload period = reload value ticks exactly; back-to-back expiries with no lost tick.
REQ-025 i_tick ignored in IDLE, PAUSED, DONE; count holds.
REQ-026 DONE: o_value holds 0, o_done high until i_clear or a valid start-load.
REQ-027 o_expire is high only in the cycle after the terminal-count edge; low otherwise, including on clear or restart.
REQ-028 Arithmetic modulo 2^WIDTH not reachable: count never decrements below 1 in RUN; no wrap to all-ones.
REQ-029 Restart in RUN (i_start with nonzero i_limit) coinciding with i_tick at count == 1: restart wins, no o_expire.

Reset
REQ-030 i_reset_n low: immediately state IDLE, count 0, reload 0, mode 0, o_expire 0, o_busy 0, o_done 0.
REQ-031 Reset deassertion: first active edge behaves as IDLE; commands sampled on that edge are honoured.
REQ-032 Reset mid-RUN or mid-PAUSED discards count and reload; no o_expire generated.

Verification
REQ-033 WIDTH=7, mode 0, start with i_limit=5, i_tick every cycle -> o_value 5,4,3,2,1,0; o_expire single pulse with o_value 0; o_done high; later ticks hold 0.
REQ-034 Mode 1, i_limit=3, i_tick continuous for 9 cycles -> o_value 3,2,1,3,2,1,3,2,1,3; o_expire every 3rd tick; o_busy stays high.
REQ-035 Mode 0, i_limit=10, pause at o_value 6 with i_tick high, 4 idle ticks, i_start with i_limit=2 -> o_value holds 6 while PAUSED, resumes 5 (no reload to 2).
REQ-036 i_clear and i_start same cycle in RUN at o_value 4 -> IDLE, o_value 0, o_busy 0; i_start with i_limit=0 in IDLE -> no change.
REQ-037 RUN at o_value 1, i_tick plus i_start with i_limit=8 same cycle -> o_value 8, no o_expire; then async reset pulse mid-count -> all outputs 0 immediately.
REQ-038 WIDTH=16, mode 0, i_limit=16'hFFFF, tick every cycle -> expiry after exactly 65535 ticks; no wrap below 0.
